// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage -- RV32I instruction decode stage.
//
// Accepts {pc, instr} from fetch, drives the register-file read addresses,
// aligns the one-cycle-late read data with the decoded fields, forwards
// same-cycle writeback data and presents one registered bundle to execute.
//
// Handshakes (both sides): a transfer happens in a cycle where valid and
// ready are both high at the rising clock edge. valid never depends on ready
// from the same side; ready may depend on the downstream ready and flush.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   if_valid/if_ready        fetch handshake
//   if_pc, if_instr          fetch bundle
//   rf_rs1_addr/rf_rs2_addr  register file read addresses
//   rf_rs1_data/rf_rs2_data  register file read data (one cycle after address)
//   wb_enable/addr/data      writeback port (same one that writes regf)
//   flush                    kill held bundle and any bundle accepted now
//   id_valid/id_ready        execute handshake
//   id_*                     decoded bundle
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter bit BYPASS_EN = 1'b1,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_instr,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            wb_enable,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [XLEN-1:0] id_imm,
    output logic [XLEN-1:0] id_rs1_val,
    output logic [XLEN-1:0] id_rs2_val,
    output logic            id_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_pc_q;
    logic [6:0]      id_opcode_q;
    logic [2:0]      id_funct3_q;
    logic [6:0]      id_funct7_q;
    logic [4:0]      id_rd_q, id_rs1_q, id_rs2_q;
    logic [XLEN-1:0] id_imm_q, imm_d;
    logic            id_illegal_q, illegal_d;
    logic            fwd1_q, fwd2_q, fwd1_d, fwd2_d;
    logic [XLEN-1:0] fwd_data1_q, fwd_data2_q;
    logic            load;
    logic [6:0]      opc;

    assign if_ready = !id_valid_q || id_ready || flush;
    assign load     = if_valid && if_ready;
    assign opc      = if_instr[6:0];

    // While stalled the held source registers are re-read every cycle so a
    // write landing during the stall reaches the operand (via forwarding for
    // one cycle, then through regf itself).
    assign rf_rs1_addr = (load && !rst) ? if_instr[19:15] : id_rs1_q;
    assign rf_rs2_addr = (load && !rst) ? if_instr[24:20] : id_rs2_q;

    // regf reads before it writes, so a write to the address being read this
    // cycle must be captured here and substituted next cycle.
    assign fwd1_d = BYPASS_EN && wb_enable && (wb_addr == rf_rs1_addr) && (wb_addr != 5'd0);
    assign fwd2_d = BYPASS_EN && wb_enable && (wb_addr == rf_rs2_addr) && (wb_addr != 5'd0);

    always_comb begin
        id_valid_d = id_valid_q;
        if (flush)         id_valid_d = 1'b0;
        else if (load)     id_valid_d = 1'b1;
        else if (id_ready) id_valid_d = 1'b0;
    end

    always_comb begin
        imm_d     = '0;
        illegal_d = 1'b0;
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM:
                imm_d = {{20{if_instr[31]}}, if_instr[31:20]};
            OPC_STORE:
                imm_d = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            OPC_BRANCH:
                imm_d = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                         if_instr[30:25], if_instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_d = {if_instr[31:12], 12'd0};
            OPC_JAL:
                imm_d = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                         if_instr[20], if_instr[30:21], 1'b0};
            OPC_OP, OPC_MISC:
                imm_d = '0;
            default: begin
                imm_d     = '0;
                illegal_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_opcode_q  <= '0;
            id_funct3_q  <= '0;
            id_funct7_q  <= '0;
            id_rd_q      <= '0;
            id_rs1_q     <= '0;
            id_rs2_q     <= '0;
            id_imm_q     <= '0;
            id_illegal_q <= 1'b0;
            fwd1_q       <= 1'b0;
            fwd2_q       <= 1'b0;
            fwd_data1_q  <= '0;
            fwd_data2_q  <= '0;
        end else begin
            id_valid_q  <= id_valid_d;
            fwd1_q      <= fwd1_d;
            fwd2_q      <= fwd2_d;
            fwd_data1_q <= wb_data;
            fwd_data2_q <= wb_data;
            if (load) begin
                id_pc_q      <= if_pc;
                id_opcode_q  <= if_instr[6:0];
                id_funct3_q  <= if_instr[14:12];
                id_funct7_q  <= if_instr[31:25];
                id_rd_q      <= if_instr[11:7];
                id_rs1_q     <= if_instr[19:15];
                id_rs2_q     <= if_instr[24:20];
                id_imm_q     <= imm_d;
                id_illegal_q <= illegal_d;
            end
        end
    end

    assign id_valid   = id_valid_q;
    assign id_pc      = id_pc_q;
    assign id_opcode  = id_opcode_q;
    assign id_funct3  = id_funct3_q;
    assign id_funct7  = id_funct7_q;
    assign id_rd      = id_rd_q;
    assign id_rs1     = id_rs1_q;
    assign id_rs2     = id_rs2_q;
    assign id_imm     = id_imm_q;
    assign id_illegal = id_illegal_q;

    assign id_rs1_val = (id_rs1_q == 5'd0) ? '0 : (fwd1_q ? fwd_data1_q : rf_rs1_data);
    assign id_rs2_val = (id_rs2_q == 5'd0) ? '0 : (fwd2_q ? fwd_data2_q : rf_rs2_data);

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [31:0] id_imm;
  logic [31:0] id_rs1_val;
  logic [31:0] id_rs2_val;
  logic        id_illegal;

  int n_vec;
  int n_err;

  decode_stage #(.BYPASS_EN(1'b1), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_illegal(id_illegal)
  );

  // clock / reset block: clock stays low until clk_en is raised
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // register file model: synchronous read, read-before-write, x0 hardwired
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (wb_enable && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
    rf_rs1_data <= regs[rf_rs1_addr];
    rf_rs2_data <= regs[rf_rs2_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = instr;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clk_en = 1'b0;
    rst = 1'b0;
    if_valid = 1'b0; if_pc = '0; if_instr = '0;
    wb_enable = 1'b0; wb_addr = '0; wb_data = '0;
    flush = 1'b0; id_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[4] = 32'd7;

    // reset with the clock idle
    #2 rst = 1'b1;
    #1;
    check_eq("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check_eq("rst_id_imm", id_imm, 32'd0);
    check_eq("rst_if_ready", {31'd0, if_ready}, 32'd1);
    check_eq("rst_rf_rs1_addr", {27'd0, rf_rs1_addr}, 32'd0);
    #5 rst = 1'b0;
    clk_en = 1'b1;
    step();

    // basic decode: addi x5,x0,-1
    id_ready = 1'b1;
    drive(32'h100, 32'hFFF00293);
    #1;
    check_eq("addi_if_ready", {31'd0, if_ready}, 32'd1);
    check_eq("addi_rf_rs2_addr", {27'd0, rf_rs2_addr}, 32'd31);
    step();
    check_eq("addi_valid", {31'd0, id_valid}, 32'd1);
    check_eq("addi_rd", {27'd0, id_rd}, 32'd5);
    check_eq("addi_rs1", {27'd0, id_rs1}, 32'd0);
    check_eq("addi_rs1_val", id_rs1_val, 32'd0);
    check_eq("addi_imm", id_imm, 32'hFFFFFFFF);
    check_eq("addi_pc", id_pc, 32'h100);
    check_eq("addi_illegal", {31'd0, id_illegal}, 32'd0);
    check_eq("addi_opcode", {25'd0, id_opcode}, 32'h13);

    // forwarding: add x1,x3,x4 accepted while x3 is written back
    drive(32'h104, 32'h004180B3);
    wb_enable = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    step();
    wb_enable = 1'b0;
    check_eq("add_rs1_val", id_rs1_val, 32'hDEADBEEF);
    check_eq("add_rs2_val", id_rs2_val, 32'd7);
    check_eq("add_rd", {27'd0, id_rd}, 32'd1);
    check_eq("add_rs1", {27'd0, id_rs1}, 32'd3);
    check_eq("add_rs2", {27'd0, id_rs2}, 32'd4);
    check_eq("add_opcode", {25'd0, id_opcode}, 32'h33);

    // stall for 3 cycles, x4 written in stall cycle 1
    id_ready = 1'b0;
    drive(32'h108, 32'hFE000EE3);
    wb_enable = 1'b1; wb_addr = 5'd4; wb_data = 32'h12;
    #1;
    check_eq("stall1_if_ready", {31'd0, if_ready}, 32'd0);
    check_eq("stall1_rf_rs2_addr", {27'd0, rf_rs2_addr}, 32'd4);
    step();
    wb_enable = 1'b0;
    check_eq("stall2_rs2_val_fwd", id_rs2_val, 32'h12);
    check_eq("stall2_pc", id_pc, 32'h104);
    check_eq("stall2_valid", {31'd0, id_valid}, 32'd1);
    check_eq("stall2_if_ready", {31'd0, if_ready}, 32'd0);
    step();
    check_eq("stall3_rs2_val_rf", id_rs2_val, 32'h12);
    check_eq("stall3_rs1_val", id_rs1_val, 32'hDEADBEEF);
    check_eq("stall3_rd", {27'd0, id_rd}, 32'd1);
    id_ready = 1'b1;
    #1;
    check_eq("unstall_if_ready", {31'd0, if_ready}, 32'd1);
    step();
    // beq x0,x0,-4 loads with no bubble
    check_eq("beq_valid", {31'd0, id_valid}, 32'd1);
    check_eq("beq_pc", id_pc, 32'h108);
    check_eq("beq_imm", id_imm, 32'hFFFFFFFC);
    check_eq("beq_illegal", {31'd0, id_illegal}, 32'd0);

    // all-zero word is illegal but still flows
    drive(32'h10C, 32'h00000000);
    step();
    check_eq("zero_valid", {31'd0, id_valid}, 32'd1);
    check_eq("zero_illegal", {31'd0, id_illegal}, 32'd1);
    check_eq("zero_imm", id_imm, 32'd0);

    // lui x0,0x12345 -> U immediate
    drive(32'h110, 32'h12345037);
    step();
    check_eq("lui_imm", id_imm, 32'h12345000);
    check_eq("lui_illegal", {31'd0, id_illegal}, 32'd0);

    // jal x0,8 -> J immediate
    drive(32'h114, 32'h0080006F);
    step();
    check_eq("jal_imm", id_imm, 32'h00000008);

    // sw x5,-8(x2) -> S immediate
    drive(32'h118, 32'hFE512C23);
    step();
    check_eq("sw_imm", id_imm, 32'hFFFFFFF8);
    check_eq("sw_funct3", {29'd0, id_funct3}, 32'd2);
    check_eq("sw_funct7", {25'd0, id_funct7}, 32'h7F);

    // flush together with a load
    drive(32'h11C, 32'h00A00513);
    flush = 1'b1;
    step();
    flush = 1'b0;
    if_valid = 1'b0;
    check_eq("flush_valid", {31'd0, id_valid}, 32'd0);

    // load addi x10,x0,10 then stall it and reset mid-cycle
    id_ready = 1'b0;
    drive(32'h120, 32'h00A00513);
    step();
    if_valid = 1'b0;
    check_eq("addi10_valid", {31'd0, id_valid}, 32'd1);
    check_eq("addi10_imm", id_imm, 32'd10);
    check_eq("addi10_rd", {27'd0, id_rd}, 32'd10);
    step();
    check_eq("addi10_hold", {31'd0, id_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_valid", {31'd0, id_valid}, 32'd0);
    check_eq("midrst_pc", id_pc, 32'd0);
    check_eq("midrst_if_ready", {31'd0, if_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();
    check_eq("postrst_valid", {31'd0, id_valid}, 32'd0);
    check_eq("postrst_if_ready", {31'd0, if_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I instruction decode stage of the core pipeline.
- Sits between fetch and execute, and is the sole read client of the register file `regf`.
- Accepts {pc, instr} from fetch over a valid/ready handshake, drives the two register-file read addresses, and aligns the synchronous read data with the decoded fields.
- Forwards same-cycle writeback data and presents one registered decoded bundle to execute.

Parameters:
BYPASS_EN  1  1 = forward writeback data into operands (required for correct results with `regf`); 0 = no forwarding, test use only.
XLEN  32  datapath width; only 32 is supported.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_valid  in  1  fetch bundle valid
if_ready  out  1  decode can accept this cycle
if_pc  in  32  instruction PC
if_instr  in  32  instruction word
rf_rs1_addr  out  5  register file read address 1
rf_rs2_addr  out  5  register file read address 2
rf_rs1_data  in  32  read data 1; registered inside regf, valid 1 cycle after address
rf_rs2_data  in  32  read data 2; same timing as rf_rs1_data
wb_enable  in  1  writeback write strobe (also drives regf)
wb_addr  in  5  writeback destination register
wb_data  in  32  writeback data
flush  in  1  kill the held bundle and any bundle accepted this cycle
id_valid  out  1  decoded bundle valid
id_ready  in  1  execute accepts the bundle
id_pc  out  32  PC of the bundle
id_opcode  out  7  instr[6:0]
id_funct3  out  3  instr[14:12]
id_funct7  out  7  instr[31:25]
id_rd  out  5  destination register
id_rs1  out  5  source register 1 index
id_rs2  out  5  source register 2 index
id_imm  out  32  sign-extended immediate
id_rs1_val  out  32  source operand 1 value
id_rs2_val  out  32  source operand 2 value
id_illegal  out  1  unsupported encoding

Behaviour:
Reset:
- All id_* outputs reset to 0, including id_valid, plus the internal forwarding flags and data.
- rf_rs*_addr reset to 0.

Handshake:
- if_ready = !id_valid || id_ready || flush.
- load = if_valid && if_ready.
- The output register updates only on load. It holds while id_valid && !id_ready.

id_valid next state:
- flush: 0, even if load.
- else load: 1.
- else id_ready: 0.
- else hold.

Latency:
- Exactly one cycle from acceptance to id_valid.

Address drive:
- rf_rsN_addr = load ? if_instr field : held id_rsN.
- This re-reads the held registers every cycle during a stall, so the operands track architectural state.

Forwarding, per operand, registered each cycle:
- fwdN <= BYPASS_EN && wb_enable && wb_addr == rf_rsN_addr && wb_addr != 0.
- fwd_dataN <= wb_data.

Operand value:
- id_rsN_val = (id_rsN == 0) ? 0 : fwdN ? fwd_dataN : rf_rsN_data.

Field extraction:
- rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7].
- These are extracted regardless of format.

Immediate, by opcode, sign-extended from instr[31]:
- I-type: LOAD, OP-IMM, JALR, SYSTEM.
- S-type: STORE.
- B-type: BRANCH, with bit 0 = 0.
- U-type: LUI, AUIPC, with low 12 bits = 0.
- J-type: JAL, with bit 0 = 0.
- OP, MISC-MEM and illegal encodings: 0.

Illegal detection:
- id_illegal = 1 unless opcode is one of: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011.
- Illegal bundles still flow through with valid = 1. The trap decision is not made here.

Simultaneous events:
- Load with id_ready in the same cycle: the new bundle replaces the old one with no bubble.
- flush wins over load.
- A wb write to the register being read in the same cycle is forwarded. A later write during a stall is seen one cycle later via re-read plus forwarding.

Reset mid-operation:
- id_valid drops immediately (async). The pending bundle is lost.
- if_ready = 1 after reset release.

Test Plan:
- Reset with clk idle: assert rst -> id_valid = 0, id_imm = 0, if_ready = 1, with no clock edge needed.
- Basic decode: accept 0xFFF00293 (addi x5,x0,-1), pc 0x100, id_ready = 1 -> next cycle id_valid = 1, id_rd = 5, id_rs1 = 0, id_rs1_val = 0, id_imm = 0xFFFFFFFF, id_pc = 0x100, id_illegal = 0.
- Forwarding: regf x3 = 0, x4 = 7; accept 0x004180B3 (add x1,x3,x4) in the same cycle as wb x3 <= 0xDEADBEEF -> id_rs1_val = 0xDEADBEEF, id_rs2_val = 7.
- Stall and late write: hold id_ready = 0 for 3 cycles after the previous bundle; wb x4 <= 0x12 in stall cycle 1 -> id_rs2_val = 0x12 from the following cycle; all other id_* stable; if_ready = 0; on id_ready = 1 a new bundle loads with no bubble.
- Immediates and illegal: 0xFE000EE3 (beq x0,x0,-4) -> id_imm = 0xFFFFFFFC; 0x00000000 -> id_illegal = 1, id_imm = 0, id_valid = 1.
- Flush: flush together with a load of 0x00A00513 -> id_valid = 0 next cycle; assert rst while a bundle is stalled -> id_valid = 0 immediately.
